// File: rtl/sumador_secuencial_parametrizable.sv
// Multi-cycle add/subtract unit: BUS-bit operands processed CHUNK bits per clock with a carry register.
// Optional signed saturation on overflow when SUMADOR_SAT_EN is defined.
module sumador_secuencial_parametrizable #(
  parameter int BUS   = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [BUS-1:0] a,
  input  logic [BUS-1:0] b,
  input  logic           sub,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [BUS-1:0] s,
  output logic           carry,
  output logic           overflow,
  output logic           zero
);

  localparam int N  = BUS / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [BUS-1:0]   a_q;
  logic [BUS-1:0]   b_q;
  logic [BUS-1:0]   s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_int_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum_full;
  logic [CHUNK-1:0] sum_chunk;
  logic             cout;
  logic             ovf_d;
  logic             last;
  logic [BUS-1:0]   s_d;
  logic             zero_d;

  always_comb begin
    a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
    sum_full  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_int_q);
    sum_chunk = sum_full[CHUNK-1:0];
    cout      = sum_full[CHUNK];
    // carry into the MSB is recovered from the MSB's own sum bit and operand bits
    ovf_d     = cout ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];
    last      = (cnt_q == CW'(N-1));
    s_d       = s_q;
    s_d[cnt_q*CHUNK +: CHUNK] = sum_chunk;
`ifdef SUMADOR_SAT_EN
    if (last && ovf_d) begin
      s_d = a_chunk[CHUNK-1] ? {1'b1, {(BUS-1){1'b0}}} : {1'b0, {(BUS-1){1'b1}}};
    end
`endif
    zero_d    = ~|s_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_int_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q         <= a;
            b_q         <= sub ? ~b : b;
            carry_int_q <= sub ? 1'b1 : cin;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          s_q         <= s_d;
          carry_int_q <= cout;
          cnt_q       <= cnt_q + CW'(1);
          if (last) begin
            carry_q <= cout;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s        = s_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
